// File: rtl/instr_refill_if.sv
// rtl/instr_refill_if.sv - memory read and cache write signal bundle for instr_refill_ctrl
//
// Groups the word-read request/response channel and the fetch-stage
// cache write / fault report signals.
//   master : the refill controller (drives requests, cache write, fault)
//   slave  : the memory system and fetch stage (drive ready and responses)
`ifndef VLEN
`define VLEN 32
`endif

interface instr_refill_if;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [`VLEN-1:2]       mem_req_addr;
    logic                   mem_rsp_valid;
    logic [31:0]            mem_rsp_data;
    logic                   mem_rsp_error;
    logic [`VLEN-1:5]       cache_port_addr;
    logic [7:0][31:0]       cache_port_data;
    logic                   cache_port_set;
    logic                   fault;
    logic [`VLEN-1:5]       fault_vaddr;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        output cache_port_addr, cache_port_data, cache_port_set,
        output fault, fault_vaddr
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        input  cache_port_addr, cache_port_data, cache_port_set,
        input  fault, fault_vaddr
    );
endinterface

// File: rtl/instr_refill_ctrl.sv
// rtl/instr_refill_ctrl.sv - instruction cache line refill controller
//
// On a fetch miss, reads the 8-word line with up to MAX_OUTSTANDING word
// reads in flight, then writes the whole line into the fetch-stage cache,
// or reports an access fault if any word came back with an error.
//   clock, reset    : sole clock, synchronous active-high reset
//   stall           : holds the cache write / fault report pending
//   miss, miss_vaddr: fetch miss request and its line address
//   abort           : redirect/flush, abandons the current refill
//   busy            : high whenever a refill is in progress
//   bus             : memory request/response and cache write/fault signals
`ifndef VLEN
`define VLEN 32
`endif

module instr_refill_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             miss,
    input  logic [`VLEN-1:5] miss_vaddr,
    input  logic             abort,
    output logic             busy,
    instr_refill_if.master   bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FAULT} state_t;

    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    state_t           state, state_next;
    logic [`VLEN-1:5] line_addr;
    logic [7:0][31:0] buffer;
    logic [3:0]       req_cnt, rsp_cnt;
    logic             err, aborted;
    logic [3:0]       in_flight;
    logic             rsp_take, rsp_fault, req_valid, req_fire, start;
    logic             set, flt;

    assign in_flight = req_cnt - rsp_cnt;
    assign start     = (state == IDLE) && miss && !abort;

    // Responses with nothing outstanding (e.g. stragglers after reset) are dropped.
    assign rsp_take  = bus.mem_rsp_valid && (req_cnt != rsp_cnt)
                       && (state == FETCH || state == DRAIN);
    assign rsp_fault = rsp_take && bus.mem_rsp_error;

    // An error beat blocks a request in its own cycle, not just from the next one.
    assign req_valid = (state == FETCH) && !abort && !err && !rsp_fault
                       && !req_cnt[3] && (in_flight < MAX_OS);
    assign req_fire  = req_valid && bus.mem_req_ready;

    assign bus.mem_req_valid   = req_valid;
    assign bus.mem_req_addr    = {line_addr, req_cnt[2:0]};
    assign bus.cache_port_set  = set;
    assign bus.cache_port_addr = line_addr;
    assign bus.cache_port_data = buffer;
    assign bus.fault           = flt;
    assign bus.fault_vaddr     = line_addr;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        set        = 1'b0;
        flt        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (abort || err || rsp_fault) state_next = DRAIN;
                else if (rsp_cnt == 4'd8)      state_next = WRITE;
            end
            DRAIN: begin
                // An abort anywhere in this refill suppresses the fault report.
                if (rsp_cnt == req_cnt)
                    state_next = (err && !aborted && !abort) ? FAULT : IDLE;
            end
            WRITE: begin
                set = !abort;
                if (abort || !stall) state_next = IDLE;
            end
            FAULT: begin
                flt = !abort;
                if (abort || !stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_cnt <= 4'd0;
            rsp_cnt <= 4'd0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else if (start) begin
            req_cnt <= 4'd0;
            rsp_cnt <= 4'd0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (req_fire) req_cnt <= req_cnt + 4'd1;
            if (rsp_take) begin
                rsp_cnt <= rsp_cnt + 4'd1;
                if (bus.mem_rsp_error) err <= 1'b1;
            end
            if (abort && (state == FETCH || state == DRAIN)) aborted <= 1'b1;
        end
    end

    // Line address and data buffer carry no reset; they are only read once written.
    always_ff @(posedge clock) begin
        if (start)    line_addr <= miss_vaddr;
        if (rsp_take) buffer[rsp_cnt[2:0]] <= bus.mem_rsp_data;
    end
endmodule

// File: tb/tb_instr_refill_ctrl.sv
// tb/tb_instr_refill_ctrl.sv - self-checking bench for instr_refill_ctrl
`ifndef VLEN
`define VLEN 32
`endif

module tb_instr_refill_ctrl;
    localparam int MAX_OS = 2;

    logic             clock = 1'b0;
    logic             reset, stall, miss, abort, busy;
    logic [`VLEN-1:5] miss_vaddr;

    instr_refill_if bus();

    instr_refill_ctrl #(.MAX_OUTSTANDING(MAX_OS)) dut (
        .clock(clock), .reset(reset), .stall(stall), .miss(miss),
        .miss_vaddr(miss_vaddr), .abort(abort), .busy(busy), .bus(bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory: answers each accepted word read in order, rsp_delay cycles later.
    typedef struct { int idx; int due; } pend_t;
    pend_t       pend[$];
    int          cyc = 0;
    int          rsp_delay = 1;
    int          err_word = -1;
    int          ready_mode = 0;
    logic [31:0] data_base = 32'h0;

    initial begin
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        bus.mem_rsp_error = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            bus.mem_req_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = data_base + 32'(pend[0].idx);
                bus.mem_rsp_error = (pend[0].idx == err_word);
                void'(pend.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = 32'h0;
                bus.mem_rsp_error = 1'b0;
            end
        end
    end

    // Transaction-level model of one refill: counts of words requested and
    // returned, error/abort flags, and whether the line write or fault report
    // is currently owed to the fetch stage.
    logic             m_active = 1'b0, m_err = 1'b0, m_aborted = 1'b0;
    logic             m_wphase = 1'b0, m_fphase = 1'b0;
    logic [`VLEN-1:5] m_line = '0;
    int               m_req = 0, m_rsp = 0;
    logic [7:0][31:0] m_exp = '0;
    logic             checking = 1'b0;

    int               n_writes = 0, n_faults = 0, n_set_cycles = 0, max_out = 0;
    int               miss_cyc = 0, first_set_cyc = -1;
    logic [7:0][31:0] last_wdata = '0;
    logic [`VLEN-1:5] last_waddr = '0;
    logic [`VLEN-1:2] first_req_addr = '0;

    task automatic compare_cycle();
        logic rsp_now, err_now, exp_valid, exp_set, exp_fault;
        int   outst;
        outst     = m_req - m_rsp;
        rsp_now   = bus.mem_rsp_valid && m_active && (outst > 0);
        err_now   = rsp_now && bus.mem_rsp_error;
        exp_valid = m_active && !m_wphase && !m_fphase && !m_err && !m_aborted
                    && !abort && !err_now && (m_req < 8) && (outst < MAX_OS);
        exp_set   = m_wphase && !abort;
        exp_fault = m_fphase && !abort;

        chk("busy", busy, m_active);
        chk("mem_req_valid", bus.mem_req_valid, exp_valid);
        if (bus.mem_req_valid) chk("mem_req_addr", bus.mem_req_addr, {m_line, 3'(m_req)});
        chk("outstanding_le_max", (outst <= MAX_OS), 1'b1);
        chk("cache_port_set", bus.cache_port_set, exp_set);
        if (bus.cache_port_set) begin
            chk("cache_port_addr", bus.cache_port_addr, m_line);
            chk("cache_port_data", bus.cache_port_data, m_exp);
            n_set_cycles++;
            if (first_set_cyc < 0) first_set_cyc = cyc;
        end
        chk("fault", bus.fault, exp_fault);
        if (bus.fault) chk("fault_vaddr", bus.fault_vaddr, m_line);

        if (reset) begin
            m_active = 1'b0; m_wphase = 1'b0; m_fphase = 1'b0;
            m_err = 1'b0; m_aborted = 1'b0; m_req = 0; m_rsp = 0;
        end else if (!m_active) begin
            if (miss && !abort) begin
                m_active = 1'b1; m_line = miss_vaddr; m_req = 0; m_rsp = 0;
                m_err = 1'b0; m_aborted = 1'b0; miss_cyc = cyc;
                for (int i = 0; i < 8; i++) m_exp[i] = data_base + 32'(i);
            end
        end else begin
            if (m_wphase) begin
                if (abort || !stall) begin
                    m_wphase = 1'b0; m_active = 1'b0;
                    if (!abort) begin
                        n_writes++;
                        last_wdata = bus.cache_port_data;
                        last_waddr = bus.cache_port_addr;
                    end
                end
            end else if (m_fphase) begin
                if (abort || !stall) begin
                    m_fphase = 1'b0; m_active = 1'b0;
                    if (!abort) n_faults++;
                end
            end else if ((m_err || m_aborted) && outst == 0) begin
                if (m_err && !m_aborted && !abort) m_fphase = 1'b1;
                else m_active = 1'b0;
            end else if (!m_err && !m_aborted && m_rsp == 8 && !abort) begin
                m_wphase = 1'b1;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                pend.push_back('{m_req % 8, cyc + rsp_delay});
                if (m_req == 0) first_req_addr = bus.mem_req_addr;
                m_req++;
            end
            if (rsp_now) begin
                m_rsp++;
                if (bus.mem_rsp_error) m_err = 1'b1;
            end
            if (abort) m_aborted = 1'b1;
        end
        if (m_req - m_rsp > max_out) max_out = m_req - m_rsp;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (checking) compare_cycle();
        end
    end

    task automatic run_refill(input logic [`VLEN-1:5] va, input logic [31:0] base,
                              input int dly, input int ew);
        data_base = base; rsp_delay = dly; err_word = ew;
        n_writes = 0; n_faults = 0; n_set_cycles = 0; max_out = 0; first_set_cyc = -1;
        miss = 1'b1; miss_vaddr = va;
        tick();
        miss = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (m_active && k < 300) begin tick(); k++; end
        chk({name, "_refill_ends"}, m_active, 1'b0);
        tick();
    endtask

    initial begin
        int k;
        reset = 1'b1; stall = 1'b0; miss = 1'b0; abort = 1'b0; miss_vaddr = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_cache_port_set", bus.cache_port_set, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        reset = 1'b0;
        checking = 1'b1;
        tick();

        // Basic line fill, 1-cycle memory.
        run_refill(27'h1234, 32'hA0, 1, -1);
        wait_idle("t1");
        chk("t1_reqs", m_req, 8);
        chk("t1_writes", n_writes, 1);
        chk("t1_latency_le_12", (first_set_cyc > miss_cyc) && (first_set_cyc - miss_cyc <= 12), 1'b1);
        chk("t1_first_addr", first_req_addr, 30'h91A0);
        chk("t1_word0", last_wdata[0], 32'hA0);
        chk("t1_word7", last_wdata[7], 32'hA7);
        chk("t1_line", last_waddr, 27'h1234);

        // Slow memory: in-flight limit reached but never exceeded.
        run_refill(27'h2468, 32'h1000_0000, 5, -1);
        wait_idle("t2");
        chk("t2_max_in_flight", max_out, MAX_OS);
        chk("t2_writes", n_writes, 1);
        chk("t2_word6", last_wdata[6], 32'h1000_0006);

        // Error on word 3.
        run_refill(27'h3333, 32'hE000_0000, 2, 3);
        wait_idle("t3");
        chk("t3_reqs", m_req, 4);
        chk("t3_writes", n_writes, 0);
        chk("t3_faults", n_faults, 1);

        // Abort after 4 requests.
        run_refill(27'h4444, 32'hB000_0000, 3, -1);
        k = 0;
        while (m_req < 4 && k < 100) begin tick(); k++; end
        chk("t4_reached_4_reqs", (m_req >= 4), 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("t4");
        chk("t4_writes", n_writes, 0);
        chk("t4_faults", n_faults, 0);
        chk("t4_reqs_le_5", (m_req <= 5), 1'b1);

        // Clean refill after abort, throttled ready, stray miss while busy.
        ready_mode = 1;
        run_refill(27'h0ABCD, 32'hC0DE_0000, 1, -1);
        repeat (3) tick();
        miss = 1'b1; miss_vaddr = 27'h7FFFF;
        tick();
        miss = 1'b0;
        wait_idle("t5");
        ready_mode = 0;
        chk("t5_writes", n_writes, 1);
        chk("t5_line", last_waddr, 27'h0ABCD);
        chk("t5_word4", last_wdata[4], 32'hC0DE_0004);

        // Stall held 3 cycles across the line write.
        stall = 1'b1;
        run_refill(27'h6666, 32'h6600_0000, 1, -1);
        k = 0;
        while (n_set_cycles < 1 && k < 100) begin tick(); k++; end
        tick();
        tick();
        stall = 1'b0;
        wait_idle("t6");
        chk("t6_set_cycles", n_set_cycles, 4);
        chk("t6_writes", n_writes, 1);

        // Reset with 2 reads outstanding; late responses must be ignored.
        run_refill(27'h7777, 32'h7700_0000, 6, -1);
        k = 0;
        while ((m_req - m_rsp) < 2 && k < 100) begin tick(); k++; end
        chk("t7_two_outstanding", m_req - m_rsp, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_busy", busy, 1'b0);
        chk("t7_req_valid", bus.mem_req_valid, 1'b0);
        chk("t7_cache_port_set", bus.cache_port_set, 1'b0);
        chk("t7_fault", bus.fault, 1'b0);
        repeat (12) tick();
        chk("t7_late_rsp_busy", busy, 1'b0);
        pend.delete();

        run_refill(27'h0808, 32'h5A00_0000, 1, -1);
        wait_idle("t8");
        chk("t8_writes", n_writes, 1);
        chk("t8_word5", last_wdata[5], 32'h5A00_0005);

        // Abort during a stalled line write: no write happens.
        stall = 1'b1;
        run_refill(27'h0909, 32'h0909_0000, 1, -1);
        k = 0;
        while (n_set_cycles < 1 && k < 100) begin tick(); k++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        stall = 1'b0;
        tick();
        chk("t9_busy", busy, 1'b0);
        chk("t9_writes", n_writes, 0);
        chk("t9_set_cycles", n_set_cycles, 1);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
